data_memory: RTL and testbench



---
 rtl/data_memory.sv | 50 +++++
 tb/tb_data_memory.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory.sv
// Word-addressed 32-bit data memory: synchronous write, combinational read,
// asynchronous active-low clear of both contents and read port.
module data_memory #(
  parameter int unsigned MEM_DEPTH = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out
);

  localparam int unsigned AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_DEPTH);

  logic [31:0]   mem_q [MEM_DEPTH];
  logic [31:0]   wr_data_d;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          wr_en;

  // Full-width compare: an X or high address never reaches the array,
  // so truncated upper bits cannot alias onto a valid word.
  always_comb begin
    in_range  = (mem_address < ADDR_LIMIT);
    idx       = mem_address[AW-1:0];
    wr_en     = mem_write && in_range;
    wr_data_d = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[idx] <= wr_data_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (rst_n && mem_read && in_range) begin
      data_out = mem_q[idx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory against an array-based reference model.
module tb_data_memory;

  localparam int unsigned DEPTH = 4000;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;

  logic [31:0] model [DEPTH];
  int          n_tests;
  int          n_fail;

  data_memory #(.MEM_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .data_out    (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic rd, input logic rn);
    if (rd && rn && a < DEPTH) return model[a];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // Drives one write across a single rising edge; the model commits at that edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_address = a;
    data_in     = d;
    mem_write   = 1'b1;
    @(posedge clk);
    if (rst_n && a < DEPTH) model[a] = d;
    #1;
    mem_write = 1'b0;
  endtask

  task automatic set_read(input logic [31:0] a, input logic rd);
    @(negedge clk);
    mem_address = a;
    mem_read    = rd;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [2];
    addrs[0] = 32'd0;
    addrs[1] = 32'd3999;
    rst_n = 1'b0;
    #7;
    model_clear();
    rst_n = 1'b1;
    foreach (addrs[k]) begin
      set_read(addrs[k], 1'b1);
      n_tests++;
      if (data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d: got %h expected 00000000", addrs[k], data_out);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(32'd5, 32'd10);
    do_write(32'd7, 32'd20);
    set_read(32'd5, 1'b1);
    n_tests++;
    if (data_out !== 32'd10) begin
      n_fail++;
      $display("FAIL wr_rd_5: got %h expected %h", data_out, 32'd10);
    end
    set_read(32'd7, 1'b1);
    n_tests++;
    if (data_out !== 32'd20) begin
      n_fail++;
      $display("FAIL wr_rd_7: got %h expected %h", data_out, 32'd20);
    end
    set_read(32'd7, 1'b0);
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL read_disabled: got %h expected 00000000", data_out);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] addrs [4];
    do_write(32'd3999, 32'hDEADBEEF);
    do_write(32'd4000, 32'h12345678);
    do_write(32'd4096 + 32'd5, 32'hAAAA5555);
    do_write(32'hFFFF_FFFF, 32'h0BAD_F00D);
    addrs[0] = 32'd3999;
    addrs[1] = 32'd4000;
    addrs[2] = 32'd0;
    addrs[3] = 32'd5;
    foreach (addrs[k]) begin
      set_read(addrs[k], 1'b1);
      n_tests++;
      if (data_out !== exp_read(addrs[k], 1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL boundary addr=%0d: got %h expected %h",
                 addrs[k], data_out, exp_read(addrs[k], 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_rw_same_cycle();
    @(negedge clk);
    mem_address = 32'd9;
    mem_read    = 1'b1;
    data_in     = 32'd55;
    mem_write   = 1'b1;
    #1;
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rw_before_edge: got %h expected 00000000", data_out);
    end
    @(posedge clk);
    model[9] = 32'd55;
    #1;
    mem_write = 1'b0;
    n_tests++;
    if (data_out !== 32'd55) begin
      n_fail++;
      $display("FAIL rw_after_edge: got %h expected %h", data_out, 32'd55);
    end
  endtask

  task automatic test_overwrite();
    @(negedge clk);
    mem_address = 32'd5;
    mem_read    = 1'b1;
    data_in     = 32'd10;
    mem_write   = 1'b1;
    @(posedge clk);
    model[5] = 32'd10;
    @(negedge clk);
    data_in = 32'd99;
    @(posedge clk);
    model[5] = 32'd99;
    #1;
    mem_write = 1'b0;
    n_tests++;
    if (data_out !== 32'd99) begin
      n_fail++;
      $display("FAIL overwrite: got %h expected %h", data_out, 32'd99);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, DEPTH - 1);
        1:       a = $urandom_range(DEPTH - 10, DEPTH + 10);
        2:       a = $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      @(negedge clk);
      mem_address = a;
      data_in     = $urandom;
      mem_read    = 1'($urandom);
      mem_write   = 1'($urandom);
      #1;
      n_tests++;
      if (data_out !== exp_read(a, mem_read, 1'b1)) begin
        n_fail++;
        $display("FAIL random_pre it=%0d addr=%h: got %h expected %h",
                 it, a, data_out, exp_read(a, mem_read, 1'b1));
      end
      @(posedge clk);
      if (mem_write && a < DEPTH) model[a] = data_in;
      #1;
      n_tests++;
      if (data_out !== exp_read(a, mem_read, 1'b1)) begin
        n_fail++;
        $display("FAIL random_post it=%0d addr=%h: got %h expected %h",
                 it, a, data_out, exp_read(a, mem_read, 1'b1));
      end
    end
    mem_write = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [31:0] addrs [3];
    do_write(32'd7, 32'd20);
    set_read(32'd7, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    n_tests++;
    if (data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_out: got %h expected 00000000", data_out);
    end
    @(negedge clk);
    mem_address = 32'd5;
    data_in     = 32'd77;
    mem_write   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    rst_n     = 1'b1;
    addrs[0] = 32'd5;
    addrs[1] = 32'd7;
    addrs[2] = 32'd3999;
    foreach (addrs[k]) begin
      set_read(addrs[k], 1'b1);
      n_tests++;
      if (data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL post_reset addr=%0d: got %h expected 00000000", addrs[k], data_out);
      end
    end
    do_write(32'd7, 32'd123);
    set_read(32'd7, 1'b1);
    n_tests++;
    if (data_out !== 32'd123) begin
      n_fail++;
      $display("FAIL write_after_release: got %h expected %h", data_out, 32'd123);
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst_n       = 1'b1;
    data_in     = '0;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    model_clear();
    test_reset();
    test_write_read();
    test_boundary();
    test_rw_same_cycle();
    test_overwrite();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
